// File: rtl/alu_pkg.sv
// Shared opcode encodings and shift-control field positions for the 8-bit ALU.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_SHF  = 3'b001;
    localparam logic [2:0] OP_BNEG = 3'b010;
    localparam logic [2:0] OP_PASS = 3'b000;

    localparam int SHF_DIR_BIT = 3;
    localparam int SHF_AMT_MSB = 2;
    localparam int SHF_AMT_W   = SHF_AMT_MSB + 1;

endpackage

// File: rtl/alu_shifter.sv
// Combinational logical shifter: left when i_dir=0, right (zero-filled) when i_dir=1.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]     i_data,
    input  logic [SHF_AMT_W-1:0] i_amt,
    input  logic                 i_dir,
    output logic [WIDTH-1:0]     o_data
);

    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;

    assign w_shl  = i_data << i_amt;
    assign w_shr  = i_data >> i_amt;
    assign o_data = i_dir ? w_shr : w_shl;

endmodule

// File: rtl/alu.sv
// ALU: add / NOR / logical shift / sign test / pass, combinational result plus
// a registered copy of the result and zero flag for the next pipeline stage.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic [2:0]       OP,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic [WIDTH-1:0] out_q,
    output logic             zero_q
);

    logic [WIDTH-1:0] w_shf;
    logic [WIDTH-1:0] w_out;
    logic             w_zero;
    logic [WIDTH-1:0] r_out_q;
    logic             r_zero_q;

    alu_shifter #(.WIDTH(WIDTH)) u_shifter (
        .i_data (input_a),
        .i_amt  (input_b[SHF_AMT_MSB:0]),
        .i_dir  (input_b[SHF_DIR_BIT]),
        .o_data (w_shf)
    );

    // OP[2] set selects ADD regardless of the low opcode bits
    always_comb begin
        w_out = input_a;
        casez (OP)
            3'b1??:  w_out = input_a + input_b;
            OP_NOR:  w_out = ~(input_a | input_b);
            OP_SHF:  w_out = w_shf;
            OP_BNEG: w_out = {{(WIDTH-1){1'b0}}, ~input_a[WIDTH-1]};
            OP_PASS: w_out = input_a;
            default: w_out = input_a;
        endcase
    end

    assign w_zero = (w_out == '0);
    assign out    = w_out;
    assign zero   = w_zero;

    // Registered result stage
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_q  <= '0;
            r_zero_q <= 1'b0;
        end else begin
            r_out_q  <= w_out;
            r_zero_q <= w_zero;
        end
    end

    assign out_q  = r_out_q;
    assign zero_q = r_zero_q;

endmodule

// File: tb/tb_alu.sv
// Directed and random stimulus for the ALU with a queue scoreboard for the registered outputs.
module tb_alu;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] input_a;
    logic [7:0] input_b;
    logic [2:0] OP;
    logic [7:0] out;
    logic       zero;
    logic [7:0] out_q;
    logic       zero_q;

    int checks = 0;
    int errors = 0;
    logic [8:0] sb_q[$];

    alu #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .input_a (input_a),
        .input_b (input_b),
        .OP      (OP),
        .out     (out),
        .zero    (zero),
        .out_q   (out_q),
        .zero_q  (zero_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
        logic [7:0] r;
        r = a;
        if (op[2]) begin
            r = a + b;
        end else if (op == 3'b011) begin
            r = ~(a | b);
        end else if (op == 3'b001) begin
            for (int i = 0; i < int'(b[2:0]); i++)
                r = b[3] ? {1'b0, r[7:1]} : {r[6:0], 1'b0};
        end else if (op == 3'b010) begin
            r = a[7] ? 8'h00 : 8'h01;
        end
        return r;
    endfunction

    task automatic step(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic rst,
                        input logic [7:0] eo, input logic ez);
        logic [8:0] e;
        @(negedge clk);
        input_a = a;
        input_b = b;
        OP      = op;
        reset   = rst;
        #1;
        check({tag, ".out"}, out, eo);
        check({tag, ".zero"}, {7'b0, zero}, {7'b0, ez});
        sb_q.push_back(rst ? 9'h000 : {eo, ez});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s.sb observed=empty expected=entry", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, ".out_q"}, out_q, e[8:1]);
            check({tag, ".zero_q"}, {7'b0, zero_q}, {7'b0, e[0]});
        end
    endtask

    initial begin
        logic [7:0] ra, rb, re;
        logic [2:0] rop;
        reset   = 1'b1;
        input_a = 8'h00;
        input_b = 8'h00;
        OP      = 3'b000;

        step("rst",      8'h00, 8'h00, 3'b000, 1'b1, 8'h00, 1'b1);
        step("nor",      8'h2D, 8'hB4, 3'b011, 1'b0, 8'h42, 1'b0);
        step("shl4",     8'h5C, 8'h04, 3'b001, 1'b0, 8'hC0, 1'b0);
        step("shr4",     8'h5C, 8'h0C, 3'b001, 1'b0, 8'h05, 1'b0);
        step("shr7",     8'h80, 8'h0F, 3'b001, 1'b0, 8'h01, 1'b0);
        step("shl3_hi",  8'h5C, 8'hF3, 3'b001, 1'b0, 8'hE0, 1'b0);
        step("shr0",     8'h5C, 8'h08, 3'b001, 1'b0, 8'h5C, 1'b0);
        step("shl7z",    8'h5C, 8'h07, 3'b001, 1'b0, 8'h00, 1'b1);
        step("shl7",     8'h03, 8'h07, 3'b001, 1'b0, 8'h80, 1'b0);
        step("bneg_pos", 8'h5C, 8'h09, 3'b010, 1'b0, 8'h01, 1'b0);
        step("bneg_neg", 8'hDC, 8'h09, 3'b010, 1'b0, 8'h00, 1'b1);
        step("add",      8'h1C, 8'h09, 3'b100, 1'b0, 8'h25, 1'b0);
        step("add_neg",  8'h1C, 8'h89, 3'b100, 1'b0, 8'hA5, 1'b0);
        step("add_wrap", 8'hFF, 8'h01, 3'b111, 1'b0, 8'h00, 1'b1);
        step("add_101",  8'h01, 8'h02, 3'b101, 1'b0, 8'h03, 1'b0);
        step("add_110",  8'h80, 8'h80, 3'b110, 1'b0, 8'h00, 1'b1);
        step("pass",     8'hAA, 8'h55, 3'b000, 1'b0, 8'hAA, 1'b0);
        step("pass_z",   8'h00, 8'hFF, 3'b000, 1'b0, 8'h00, 1'b1);
        step("reg_load", 8'h1C, 8'h09, 3'b100, 1'b0, 8'h25, 1'b0);
        step("reg_rst",  8'h1C, 8'h09, 3'b100, 1'b1, 8'h25, 1'b0);
        step("reg_rel",  8'h1C, 8'h09, 3'b100, 1'b0, 8'h25, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rop = 3'($urandom_range(0, 7));
            re  = model(ra, rb, rop);
            step("rand", ra, rb, rop, 1'b0, re, (re == 8'h00));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
